// File: rtl/score_uart_pkg.sv
// score_uart_pkg: shared constants, FSM state type and hex helper for the score UART transmitter
package score_uart_pkg;

    localparam logic [7:0] ASCII_S     = 8'h53;
    localparam logic [7:0] ASCII_COMMA = 8'h2C;
    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_A     = 8'h41;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    localparam int FRAME_LEN = 15;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_e;

    // Uppercase ASCII hex digit for one nibble
    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        return (nib < 4'd10) ? ASCII_0 + {4'd0, nib} : ASCII_A + {4'd0, nib} - 8'd10;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 serializer for one byte; a start seen in the last stop-bit cycle chains the next byte with no gap
module uart_tx_byte
    import score_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       Clk,
    input  logic       reset_rtl_0,
    input  logic       start,
    input  logic [7:0] data,
    output logic       txd,
    output logic       done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    tx_state_e     state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic          txd_q;
    logic          bit_end;

    assign bit_end = (cnt_q == CNT_LAST);
    assign done    = (state_q == ST_STOP) && bit_end;
    assign txd     = txd_q;

    // Bit-level FSM: baud counter, bit counter, shift register and registered line output
    always_ff @(posedge Clk or negedge reset_rtl_0) begin
        if (!reset_rtl_0) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
        end else begin
            cnt_q <= bit_end ? '0 : cnt_q + CW'(1);
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (start) begin
                        state_q <= ST_START;
                        shift_q <= data;
                        txd_q   <= 1'b0;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        state_q <= ST_DATA;
                        bit_q   <= '0;
                        txd_q   <= shift_q[0];
                        shift_q <= shift_q >> 1;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        if (bit_q == 3'd7) begin
                            state_q <= ST_STOP;
                            txd_q   <= 1'b1;
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            txd_q   <= shift_q[0];
                            shift_q <= shift_q >> 1;
                        end
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        if (start) begin
                            state_q <= ST_START;
                            shift_q <= data;
                            txd_q   <= 1'b0;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    txd_q   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/score_uart_tx.sv
// score_uart_tx: sends a 15-byte ASCII status frame (scores, game state, game-over flags) over 8N1 UART
module score_uart_tx
    import score_uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int BAUD        = 115200
) (
    input  logic        Clk,
    input  logic        reset_rtl_0,
    input  logic        send,
    input  logic [15:0] score,
    input  logic [15:0] score2,
    input  logic [2:0]  outputState,
    input  logic        gameOverFromBall,
    input  logic        gameOverFromBall2,
    output logic        busy,
    output logic        frame_done,
    output logic        txd
);

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;

    logic        s1_q, s2_q, s3_q;
    logic        busy_q, busy_d;
    logic        frame_done_q, frame_done_d;
    logic [3:0]  idx_q, idx_d;
    logic [15:0] sc1_q, sc1_d, sc2_q, sc2_d;
    logic [2:0]  st_q, st_d;
    logic [1:0]  go_q, go_d;
    logic        req, accept, last_byte, byte_done, byte_start;
    logic [3:0]  next_idx;
    logic [7:0]  next_byte, byte_data;

    assign req        = s2_q & ~s3_q;
    assign accept     = req & ~busy_q;
    assign last_byte  = (idx_q == 4'(FRAME_LEN - 1));
    assign next_idx   = idx_q + 4'd1;
    assign byte_start = accept | (busy_q & byte_done & ~last_byte);
    assign byte_data  = busy_q ? next_byte : ASCII_S;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

    // Byte that follows the current one, taken from the frozen snapshot
    always_comb begin
        case (next_idx)
            4'd1:    next_byte = hex_ascii(sc1_q[15:12]);
            4'd2:    next_byte = hex_ascii(sc1_q[11:8]);
            4'd3:    next_byte = hex_ascii(sc1_q[7:4]);
            4'd4:    next_byte = hex_ascii(sc1_q[3:0]);
            4'd5:    next_byte = ASCII_COMMA;
            4'd6:    next_byte = hex_ascii(sc2_q[15:12]);
            4'd7:    next_byte = hex_ascii(sc2_q[11:8]);
            4'd8:    next_byte = hex_ascii(sc2_q[7:4]);
            4'd9:    next_byte = hex_ascii(sc2_q[3:0]);
            4'd10:   next_byte = ASCII_COMMA;
            4'd11:   next_byte = ASCII_0 + {5'd0, st_q};
            4'd12:   next_byte = ASCII_0 + {6'd0, go_q};
            4'd13:   next_byte = ASCII_CR;
            4'd14:   next_byte = ASCII_LF;
            default: next_byte = ASCII_S;
        endcase
    end

    // Frame sequencing: accept a request when idle, advance the byte index, end the frame
    always_comb begin
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        idx_d        = idx_q;
        sc1_d        = sc1_q;
        sc2_d        = sc2_q;
        st_d         = st_q;
        go_d         = go_q;
        if (accept) begin
            busy_d = 1'b1;
            idx_d  = '0;
            sc1_d  = score;
            sc2_d  = score2;
            st_d   = outputState;
            go_d   = {gameOverFromBall2, gameOverFromBall};
        end else if (busy_q && byte_done) begin
            if (last_byte) begin
                busy_d       = 1'b0;
                frame_done_d = 1'b1;
            end else begin
                idx_d = next_idx;
            end
        end
    end

    // State registers, including the send synchronizer and edge flop
    always_ff @(posedge Clk or negedge reset_rtl_0) begin
        if (!reset_rtl_0) begin
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            s3_q         <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            idx_q        <= '0;
            sc1_q        <= '0;
            sc2_q        <= '0;
            st_q         <= '0;
            go_q         <= '0;
        end else begin
            s1_q         <= send;
            s2_q         <= s1_q;
            s3_q         <= s2_q;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            idx_q        <= idx_d;
            sc1_q        <= sc1_d;
            sc2_q        <= sc2_d;
            st_q         <= st_d;
            go_q         <= go_d;
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .Clk        (Clk),
        .reset_rtl_0(reset_rtl_0),
        .start      (byte_start),
        .data       (byte_data),
        .txd        (txd),
        .done       (byte_done)
    );

endmodule

// File: tb/tb_score_uart_tx.sv
// tb_score_uart_tx: directed and randomized frame checks against a string-level frame model
module tb_score_uart_tx;

    localparam int CPB   = 10;
    localparam int FBITS = 150;
    localparam int FCYC  = FBITS * CPB;

    logic        Clk;
    logic        reset_rtl_0;
    logic        send;
    logic [15:0] score;
    logic [15:0] score2;
    logic [2:0]  outputState;
    logic        gameOverFromBall;
    logic        gameOverFromBall2;
    logic        busy;
    logic        frame_done;
    logic        txd;

    int checks = 0;
    int errors = 0;
    int fd_count = 0;
    int rise_cnt = 0;
    bit busy_prev = 0;

    score_uart_tx #(
        .CLK_FREQ_HZ(100_000_000),
        .BAUD       (10_000_000)
    ) dut (
        .Clk              (Clk),
        .reset_rtl_0      (reset_rtl_0),
        .send             (send),
        .score            (score),
        .score2           (score2),
        .outputState      (outputState),
        .gameOverFromBall (gameOverFromBall),
        .gameOverFromBall2(gameOverFromBall2),
        .busy             (busy),
        .frame_done       (frame_done),
        .txd              (txd)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (frame_done === 1'b1) fd_count++;
        if (busy === 1'b1 && !busy_prev) rise_cnt++;
        busy_prev = (busy === 1'b1);
    end

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Frame text built from the human-readable format: "S" hex4 "," hex4 "," state flags CR LF
    function automatic logic [119:0] model_frame(input logic [15:0] a, input logic [15:0] b,
                                                 input logic [2:0] st, input logic g1, input logic g2);
        string hexd;
        string s;
        logic [119:0] v;
        hexd = "0123456789ABCDEF";
        s = "S";
        for (int i = 3; i >= 0; i--) begin
            int n;
            n = int'((a >> (4 * i)) & 16'hF);
            s = {s, hexd.substr(n, n)};
        end
        s = {s, ","};
        for (int i = 3; i >= 0; i--) begin
            int n;
            n = int'((b >> (4 * i)) & 16'hF);
            s = {s, hexd.substr(n, n)};
        end
        s = {s, ",", $sformatf("%0d%0d", st, {g2, g1}), "\r\n"};
        v = '0;
        for (int i = 0; i < 15; i++) v[119 - 8 * i -: 8] = s[i];
        return v;
    endfunction

    // Line level expected during serial bit k of the frame (start 0, 8 data LSB first, stop 1)
    function automatic logic exp_bit(input logic [119:0] v, input int k);
        logic [7:0] b;
        int p;
        b = v[119 - 8 * (k / 10) -: 8];
        p = k % 10;
        return (p == 0) ? 1'b0 : (p == 9) ? 1'b1 : b[p - 1];
    endfunction

    // mode 0: plain pulse, 1: mid-frame input change + extra send, 2: send held, 3: reset at cycle 700
    task automatic do_frame(input string tag, input logic [15:0] a, input logic [15:0] b,
                            input logic [2:0] st, input logic g1, input logic g2, input int mode);
        logic [119:0] exp_v;
        logic [119:0] got_v;
        int wave_err;
        int fd0;
        score = a;
        score2 = b;
        outputState = st;
        gameOverFromBall = g1;
        gameOverFromBall2 = g2;
        exp_v = model_frame(a, b, st, g1, g2);
        got_v = '0;
        wave_err = 0;
        fd0 = fd_count;
        send = 1'b1;
        tick;
        chk({tag, "_lat_k"}, {127'd0, txd}, 128'd1);
        tick;
        chk({tag, "_lat_k1"}, {127'd0, txd}, 128'd1);
        tick;
        chk({tag, "_start_edge"}, {126'd0, txd, busy}, 128'd1);
        if (mode != 2) send = 1'b0;
        for (int j = 0; j < FCYC; j++) begin
            if (mode == 3 && j == 700) begin
                #2 reset_rtl_0 = 1'b0;
                #1 chk({tag, "_async_reset"}, {125'd0, txd, busy, frame_done}, 128'd4);
                tick;
                tick;
                tick;
                reset_rtl_0 = 1'b1;
                return;
            end
            if (mode == 1 && j == 200) begin
                score = 16'hFFFF;
                send = 1'b1;
            end
            if (mode == 1 && j == 203) send = 1'b0;
            if (txd !== exp_bit(exp_v, j / CPB) || busy !== 1'b1 || frame_done !== 1'b0) wave_err++;
            if (j % CPB == CPB / 2 && (j / CPB) % 10 >= 1 && (j / CPB) % 10 <= 8)
                got_v[112 - 8 * (j / 100) + (j / CPB) % 10 - 1] = txd;
            tick;
        end
        chk({tag, "_waveform_errs"}, 128'(wave_err), 128'd0);
        chk({tag, "_bytes"}, {8'd0, got_v}, {8'd0, exp_v});
        chk({tag, "_end_txd_busy_done"}, {125'd0, txd, busy, frame_done}, 128'd5);
        tick;
        chk({tag, "_done_width"}, {127'd0, frame_done}, 128'd0);
        chk({tag, "_done_count"}, 128'(fd_count - fd0), 128'd1);
    endtask

    initial begin
        int idle_err;
        int r0;
        reset_rtl_0 = 1'b0;
        send = 1'b0;
        score = '0;
        score2 = '0;
        outputState = '0;
        gameOverFromBall = 1'b0;
        gameOverFromBall2 = 1'b0;
        tick;
        tick;
        chk("reset_txd", {127'd0, txd}, 128'd1);
        chk("reset_busy", {127'd0, busy}, 128'd0);
        chk("reset_done", {127'd0, frame_done}, 128'd0);
        reset_rtl_0 = 1'b1;

        idle_err = 0;
        for (int i = 0; i < 2000; i++) begin
            if (txd !== 1'b1 || busy !== 1'b0) idle_err++;
            tick;
        end
        chk("idle_2000", 128'(idle_err), 128'd0);

        do_frame("directed", 16'h1234, 16'h00AF, 3'd3, 1'b1, 1'b0, 0);
        repeat (20) tick;

        do_frame("snapshot", 16'h1234, 16'h00AF, 3'd5, 1'b0, 1'b1, 1);
        r0 = rise_cnt;
        repeat (2000) tick;
        chk("snapshot_no_second", 128'(rise_cnt - r0), 128'd0);

        do_frame("held", 16'hBEEF, 16'h0C0D, 3'd7, 1'b1, 1'b1, 2);
        r0 = rise_cnt;
        repeat (5000 - FCYC - 4) tick;
        send = 1'b0;
        repeat (20) tick;
        chk("held_no_retrigger", 128'(rise_cnt - r0), 128'd0);

        for (int n = 0; n < 3; n++) begin
            do_frame($sformatf("rand%0d", n), 16'($urandom), 16'($urandom), 3'($urandom_range(0, 7)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
            repeat ($urandom_range(1, 30)) tick;
        end

        do_frame("midreset", 16'h5A5A, 16'hA5A5, 3'd2, 1'b0, 1'b0, 3);
        idle_err = 0;
        for (int i = 0; i < 100; i++) begin
            if (txd !== 1'b1 || busy !== 1'b0) idle_err++;
            tick;
        end
        chk("after_reset_idle", 128'(idle_err), 128'd0);
        do_frame("post_reset", 16'($urandom), 16'($urandom), 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/score_uart_tx.md
Name: score_uart_tx

Overview:
Outbound counterpart to the USB keycode input path. Sends a fixed 15-byte ASCII status frame over 8N1 UART to the host PC. The frame holds both players' scores, the game FSM state and both game-over flags. Sits beside mb_block in the top level and drives a dedicated txd pin; the send request comes from a vsync-derived strobe.

Parameters:
CLK_FREQ_HZ, 100_000_000, frequency of Clk in Hz
BAUD, 115200, line rate; CLKS_PER_BIT = CLK_FREQ_HZ / BAUD, truncated (868 at defaults)

Ports:
Clk  input  1  system clock, 100 MHz
reset_rtl_0  input  1  asynchronous active-low reset
send  input  1  frame request, asynchronous level; each rising edge requests one frame
score  input  16  player 1 score, sent as 4 hex digits
score2  input  16  player 2 score, sent as 4 hex digits
outputState  input  3  game FSM state
gameOverFromBall  input  1  player 1 game-over flag
gameOverFromBall2  input  1  player 2 game-over flag
busy  output  1  high while a frame is in flight
frame_done  output  1  one-cycle pulse at the end of the last stop bit
txd  output  1  UART serial out; idles high

Behaviour:
- Reset (reset_rtl_0 = 0, asynchronous, any time including mid-frame):
  - txd = 1, busy = 0, frame_done = 0.
  - FSM returns to IDLE; synchronizer flops, snapshot and counters clear.
  - After release, the first frame needs a fresh rising edge of send.
- send path:
  - Two-flop synchronizer (s1, s2) plus edge flop s3; req = s2 & ~s3.
  - txd falls (start bit) on the 3rd Clk rising edge after send is first sampled high.
  - busy rises on that same edge.
- Snapshot: on the accept edge, score, score2, outputState and both flags are registered. Input changes during a frame do not affect it.
- Frame bytes, in order:
  - 'S' (0x53)
  - score hex, MS nibble first
  - ',' (0x2C)
  - score2 hex, MS nibble first
  - ','
  - '0' + outputState
  - '0' + {gameOverFromBall2, gameOverFromBall}
  - 0x0D, 0x0A
- Hex digits are uppercase: nibble 0-9 maps to 0x30+n, 10-15 maps to 0x41+(n-10).
- Each byte is sent as 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
- Each bit lasts exactly CLKS_PER_BIT cycles. There are no idle gaps between bytes.
- Frame length is 150 * CLKS_PER_BIT cycles.
- FSM states and transitions:
  - IDLE: on req, snapshot inputs and go to START with byte index = 0.
  - START: drive 0 for one bit time, then go to DATA.
  - DATA: drive 8 bits; bit counter runs 0..7, then go to STOP.
  - STOP: drive 1 for one bit time. If byte index = 14, go to IDLE and pulse frame_done. Otherwise increment the index and go to START.
- Counters:
  - Baud counter is ceil(log2(CLKS_PER_BIT)) bits wide and counts 0..CLKS_PER_BIT-1.
  - Byte index is 4 bits.
- frame_done and busy falling occur on the same edge; txd is already 1 from the stop bit.
- req while busy is dropped, not queued. A send level held high across a frame does not retrigger.
- req on the same edge that busy falls is dropped; a new edge is required.
- Invalid or unused FSM encodings recover to IDLE with txd = 1.

Decomposition:
- Package score_uart_pkg holds:
  - ASCII constants: 'S', ',', '0', 'A', CR, LF
  - FRAME_LEN = 15
  - FSM state enum
  - function hex_ascii(nibble) returning the byte
- One sub-module, uart_tx_byte: serializes a single byte.
  - Inputs: Clk, reset_rtl_0, start, data[7:0].
  - Outputs: txd, done.
  - score_uart_tx sequences bytes into it.

Test Plan (BAUD = 10_000_000 so CLKS_PER_BIT = 10; frame = 1500 cycles):
- Idle after reset, no send -> txd = 1, busy = 0 for 2000 cycles.
- score=0x1234, score2=0x00AF, outputState=3, GO1=1, GO2=0, send pulse -> decoded bytes 53 31 32 33 34 2C 30 30 41 46 2C 33 31 0D 0A; frame_done pulses exactly once, 1500 cycles after txd first falls.
- Latency and bit timing: send rises before edge k -> txd = 0 from edge k+2; every bit is exactly 10 cycles.
- Snapshot and drop: change score to 0xFFFF and pulse send again 200 cycles into a frame -> the frame still carries 0x1234 digits, and no second frame follows.
- Held send: send high for 5000 cycles -> exactly one frame.
- Reset mid-frame: assert reset_rtl_0 low at cycle 700 of a frame -> txd = 1 and busy = 0 immediately (asynchronous); after release and a new send edge, a complete correct frame is sent.
